player_b_adaptive: RTL and testbench

- Opponent player for the iterated prisoner's dilemma match. Drives action_B and consumes the other player's action_A over the same one-bit-per-round interface.
- Strategy is tit-for-two-tats, with a windowed grudge mode and an end-game defection override.
- Keeps the round count and its own payoff score, and flags when the match is over.
- Sits opposite the A-side player in the match top level; one clock edge is one round.

---
 rtl/pd_pkg.sv | 32 +++
 rtl/pd_history_window.sv | 38 +++
 rtl/player_b_adaptive.sv | 150 +++++++++++++++
 tb/tb_player_b_adaptive.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types and payoff constants for the iterated prisoner's dilemma match.
// Combinational helpers only: no latency, no flow control.
package pd_pkg;

    localparam logic COOPERATE = 1'b0;
    localparam logic DEFECT    = 1'b1;

    localparam logic [2:0] PAY_R = 3'd3;
    localparam logic [2:0] PAY_S = 3'd0;
    localparam logic [2:0] PAY_T = 3'd5;
    localparam logic [2:0] PAY_P = 3'd1;

    typedef enum logic [2:0] {
        COOP,
        RETALIATE,
        GRUDGE,
        ENDGAME,
        DONE
    } state_t;

    function automatic logic [2:0] payoff_b(input logic a_move, input logic b_move);
        logic [2:0] pay;
        case ({a_move, b_move})
            2'b00:   pay = PAY_R;
            2'b10:   pay = PAY_S;
            2'b01:   pay = PAY_T;
            default: pay = PAY_P;
        endcase
        return pay;
    endfunction

endpackage

// File: rtl/pd_history_window.sv
// Sliding window of opponent moves; wcount/last_two reflect the window after shifting in a_in.
// Updates one round per enabled edge; no backpressure, shift_en simply freezes it.
module pd_history_window #(
    parameter int WINDOW = 8,
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_en,
    input  logic          a_in,
    output logic [CW-1:0] wcount,
    output logic [1:0]    last_two
);

    logic [WINDOW-1:0] win_q;
    logic [WINDOW-1:0] win_d;
    logic [WINDOW-1:0] shifted;

    always_comb begin
        shifted = {win_q[WINDOW-2:0], a_in};
        win_d   = shift_en ? shifted : win_q;
        wcount  = '0;
        for (int i = 0; i < WINDOW; i++) begin
            wcount = wcount + CW'(shifted[i]);
        end
        // Cleared window yields 0 for the "previous round" bit in round 0.
        last_two = {win_q[0], a_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/player_b_adaptive.sv
// B-side player: tit-for-two-tats with windowed grudge and end-game defection; one edge = one round.
// Response latency 1 round; no backpressure, a move is consumed on every edge until the match is done.
module player_b_adaptive #(
    parameter int NUM_ROUNDS   = 200,
    parameter int WINDOW       = 8,
    parameter int DEFECT_LIMIT = 3,
    parameter int GRUDGE_LEN   = 5,
    parameter int ENDGAME      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        action_A,
    output logic        action_B,
    output logic [15:0] round_count,
    output logic [15:0] score_B,
    output logic [15:0] a_defect_count,
    output logic        match_done
);

    import pd_pkg::*;

    localparam int          CW           = $clog2(WINDOW + 1);
    localparam int          GW           = $clog2(GRUDGE_LEN + 1);
    localparam logic [15:0] LAST_ROUND   = 16'(NUM_ROUNDS - 1);
    localparam logic [31:0] ENDGAME_FROM = 32'(NUM_ROUNDS - ENDGAME);
    localparam logic [GW-1:0] GRUDGE_LOAD = GW'(GRUDGE_LEN);

    state_t         state_q, state_d, coop_next;
    logic           action_b_q, action_b_d;
    logic [15:0]    round_q, round_d;
    logic [15:0]    score_q, score_d;
    logic [15:0]    adc_q, adc_d;
    logic           done_q, done_d;
    logic [GW-1:0]  grudge_q, grudge_d;

    logic [CW-1:0]  wcount;
    logic [1:0]     last_two;
    logic           round_active;
    logic           grudge_hit;
    logic [16:0]    score_sum;

    assign round_active = (state_q != DONE);

    pd_history_window #(
        .WINDOW (WINDOW),
        .CW     (CW)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .shift_en (round_active),
        .a_in     (action_A),
        .wcount   (wcount),
        .last_two (last_two)
    );

    always_comb begin
        state_d    = state_q;
        action_b_d = action_b_q;
        round_d    = round_q;
        score_d    = score_q;
        adc_d      = adc_q;
        done_d     = done_q;
        grudge_d   = grudge_q;
        score_sum  = {1'b0, score_q} + 17'(payoff_b(action_A, action_b_q));
        grudge_hit = (32'(wcount) >= 32'(DEFECT_LIMIT));

        if (grudge_hit) begin
            coop_next = GRUDGE;
        end else if (last_two == 2'b11) begin
            coop_next = RETALIATE;
        end else begin
            coop_next = COOP;
        end

        if (round_active) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (action_A == DEFECT && adc_q != 16'hFFFF) begin
                adc_d = adc_q + 16'd1;
            end
            if (round_q != 16'hFFFF) begin
                round_d = round_q + 16'd1;
            end

            case (state_q)
                COOP:      state_d = coop_next;
                RETALIATE: begin
                    if (grudge_hit) begin
                        state_d = GRUDGE;
                    end else if (action_A == COOPERATE) begin
                        state_d = COOP;
                    end
                end
                GRUDGE: begin
                    // The round the grudge expires is judged like a COOP round,
                    // so a still-hostile window re-arms the grudge without a gap.
                    if (grudge_q <= GW'(1)) begin
                        grudge_d = '0;
                        state_d  = coop_next;
                    end else begin
                        grudge_d = grudge_q - GW'(1);
                    end
                end
                default:   state_d = state_q;
            endcase

            if (state_d == GRUDGE && (state_q != GRUDGE || grudge_q <= GW'(1))) begin
                grudge_d = GRUDGE_LOAD;
            end

            if (ENDGAME > 0 && ({16'b0, round_q} + 32'd1) >= ENDGAME_FROM) begin
                state_d = pd_pkg::ENDGAME;
            end

            if (round_q == LAST_ROUND) begin
                state_d = DONE;
                done_d  = 1'b1;
            end

            action_b_d = (state_d == RETALIATE) || (state_d == GRUDGE)
                      || (state_d == pd_pkg::ENDGAME);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COOP;
            action_b_q <= COOPERATE;
            round_q    <= '0;
            score_q    <= '0;
            adc_q      <= '0;
            done_q     <= 1'b0;
            grudge_q   <= '0;
        end else begin
            state_q    <= state_d;
            action_b_q <= action_b_d;
            round_q    <= round_d;
            score_q    <= score_d;
            adc_q      <= adc_d;
            done_q     <= done_d;
            grudge_q   <= grudge_d;
        end
    end

    assign action_B       = action_b_q;
    assign round_count    = round_q;
    assign score_B        = score_q;
    assign a_defect_count = adc_q;
    assign match_done     = done_q;

endmodule

// File: tb/tb_player_b_adaptive.sv
// Directed match scenarios for player_b_adaptive with hand-computed expectations.
module tb_player_b_adaptive;

    logic        clk = 1'b0;
    logic        reset;
    logic        action_A;
    logic        action_B;
    logic [15:0] round_count;
    logic [15:0] score_B;
    logic [15:0] a_defect_count;
    logic        match_done;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    player_b_adaptive dut (
        .clk            (clk),
        .reset          (reset),
        .action_A       (action_A),
        .action_B       (action_B),
        .round_count    (round_count),
        .score_B        (score_B),
        .a_defect_count (a_defect_count),
        .match_done     (match_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic a);
        action_A = a;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        action_A = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic chk_totals(input string tag, input int sc, input int adc, input int rc, input int dn);
        chk({tag, " score"},  32'(score_B),        32'(sc));
        chk({tag, " adc"},    32'(a_defect_count), 32'(adc));
        chk({tag, " rounds"}, 32'(round_count),    32'(rc));
        chk({tag, " done"},   32'(match_done),     32'(dn));
    endtask

    initial begin
        reset    = 1'b1;
        action_A = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("reset action_B", 32'(action_B), 32'd0);
        chk_totals("reset", 0, 0, 0, 0);

        // A always cooperates: end-game defection in the last two rounds.
        for (int r = 0; r < 200; r++) begin
            chk($sformatf("allcoop B r%0d", r), 32'(action_B), (r >= 198) ? 32'd1 : 32'd0);
            step(1'b0);
        end
        chk_totals("allcoop end", 604, 0, 200, 1);
        chk("allcoop done B", 32'(action_B), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk_totals($sformatf("allcoop frozen%0d", k), 604, 0, 200, 1);
            chk($sformatf("allcoop frozen B%0d", k), 32'(action_B), 32'd0);
        end

        do_reset();
        chk_totals("reset2", 0, 0, 0, 0);

        // Single defection in round 10 is forgiven.
        for (int r = 0; r <= 20; r++) begin
            chk($sformatf("single B r%0d", r), 32'(action_B), 32'd0);
            if (r == 20) chk_totals("single r20", 57, 1, 20, 0);
            step(r == 10);
        end

        do_reset();
        // Two consecutive defections: one round of retaliation.
        for (int r = 0; r <= 20; r++) begin
            chk($sformatf("pair B r%0d", r), 32'(action_B), (r == 12) ? 32'd1 : 32'd0);
            if (r == 20) chk_totals("pair r20", 56, 2, 20, 0);
            step(r == 10 || r == 11);
        end

        do_reset();
        // Three scattered defections inside the window: grudge for five rounds.
        for (int r = 0; r < 32; r++) begin
            chk($sformatf("grudge B r%0d", r), 32'(action_B),
                (r >= 25 && r <= 29) ? 32'd1 : 32'd0);
            step(r == 20 || r == 22 || r == 24);
        end
        chk_totals("grudge r32", 97, 3, 32, 0);

        do_reset();
        // Reset mid-match while retaliating with defections in the window.
        for (int r = 0; r < 50; r++) begin
            step(r == 48 || r == 49);
        end
        chk("midreset pre B", 32'(action_B), 32'd1);
        chk_totals("midreset pre", 144, 2, 50, 0);
        reset    = 1'b1;
        action_A = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset B", 32'(action_B), 32'd0);
        chk_totals("midreset", 0, 0, 0, 0);
        // A stale window or state would make B defect here.
        for (int r = 0; r < 12; r++) begin
            chk($sformatf("replay B r%0d", r), 32'(action_B), 32'd0);
            step(r == 0);
        end
        chk_totals("replay r12", 33, 1, 12, 0);

        do_reset();
        // A always defects.
        for (int r = 0; r < 200; r++) begin
            chk($sformatf("alldef B r%0d", r), 32'(action_B), (r >= 2) ? 32'd1 : 32'd0);
            step(1'b1);
        end
        chk_totals("alldef end", 198, 200, 200, 1);
        chk("alldef done B", 32'(action_B), 32'd0);
        step(1'b0);
        step(1'b1);
        chk_totals("alldef frozen", 198, 200, 200, 1);
        chk("alldef frozen B", 32'(action_B), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
